// File: rtl/stream_mux_arb.sv
// stream_mux_arb: packet-boundary round-robin arbiter for a 2:1 stream mux with forced owner and stall watchdog
// Ports:
//   ACLK, ARESETN                    clock, asynchronous active-low reset
//   S0_TVALID/S0_TLAST/S0_TREADY     source 0 handshake
//   S1_TVALID/S1_TLAST/S1_TREADY     source 1 handshake
//   M_TVALID/M_TLAST/M_TREADY        sink handshake
//   FORCE_EN, FORCE_SEL              restrict grants to one source
//   SEL                              registered mux select (0 = source 0)
//   BUSY                             registered, high while a packet is granted
//   TIMEOUT_PULSE                    one-cycle pulse on watchdog revoke
//   ABORT_CNT                        saturating count of watchdog revokes
module stream_mux_arb #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             S0_TVALID,
    input  logic             S0_TLAST,
    output logic             S0_TREADY,
    input  logic             S1_TVALID,
    input  logic             S1_TLAST,
    output logic             S1_TREADY,
    output logic             M_TVALID,
    output logic             M_TLAST,
    input  logic             M_TREADY,
    input  logic             FORCE_EN,
    input  logic             FORCE_SEL,
    output logic             SEL,
    output logic             BUSY,
    output logic             TIMEOUT_PULSE,
    output logic [CNT_W-1:0] ABORT_CNT
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);
    state_t state, next;
    logic last_owner, req, pick, granted, own_vld, own_last, beat, stall, expire;
    logic [CNT_W-1:0] stall_cnt;
    assign granted  = state == GRANT;
    assign own_vld  = SEL ? S1_TVALID : S0_TVALID;
    assign own_last = SEL ? S1_TLAST : S0_TLAST;
    assign beat     = M_TVALID & M_TREADY;
    assign stall    = granted & ~own_vld;
    // Backpressure never counts as a stall: only an absent source beat does.
    assign expire   = (TIMEOUT != 0) && stall && stall_cnt == STALL_MAX;
    // Forced mode only ever considers FORCE_SEL; otherwise the loser of the last packet wins ties.
    always_comb begin
        req  = FORCE_EN ? (FORCE_SEL ? S1_TVALID : S0_TVALID) : (S0_TVALID | S1_TVALID);
        pick = FORCE_EN ? FORCE_SEL : ((S0_TVALID & S1_TVALID) ? ~last_owner : S1_TVALID);
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= next;
    end
    always_comb begin
        next = state;
        if (state == IDLE) next = req ? GRANT : IDLE;
        else if ((beat & M_TLAST) | expire) next = IDLE;
    end
    always_comb begin
        M_TVALID  = granted & own_vld;
        M_TLAST   = granted & own_last;
        S0_TREADY = granted & ~SEL & M_TREADY;
        S1_TREADY = granted & SEL & M_TREADY;
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            SEL           <= 1'b0;
            last_owner    <= 1'b1;
            BUSY          <= 1'b0;
            TIMEOUT_PULSE <= 1'b0;
            stall_cnt     <= '0;
            ABORT_CNT     <= '0;
        end else begin
            if (state == IDLE && req) SEL <= pick;
            if (granted && next == IDLE) last_owner <= SEL;
            BUSY          <= next == GRANT;
            TIMEOUT_PULSE <= expire;
            if (expire && ~&ABORT_CNT) ABORT_CNT <= ABORT_CNT + 1'b1;
            stall_cnt <= (!granted || beat || expire) ? '0 :
                         (stall && TIMEOUT != 0) ? stall_cnt + 1'b1 : stall_cnt;
        end
    end
endmodule
